// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central stall/flush controller for the 5-stage pipeline.
// Combines register-dependency stalls (Tuse/Tnew comparison against the E
// and M stage destinations) with a multiply/divide busy sequencer, and
// drives the PC / F/D hold enables and the D/E bubble clear.
// Optional feature: define HAZARD_CTRL_STALL_CNT_EN to add a 32-bit
// free-running stall-cycle counter output (stall_cnt).
module hazard_ctrl #(
  parameter int ADDR_W      = 5,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] d_rs,
  input  logic [ADDR_W-1:0] d_rt,
  input  logic [1:0]        d_tuse_rs,
  input  logic [1:0]        d_tuse_rt,
  input  logic              d_md_use,
  input  logic [ADDR_W-1:0] e_wa,
  input  logic [1:0]        e_tnew,
  input  logic [ADDR_W-1:0] m_wa,
  input  logic [1:0]        m_tnew,
  input  logic              e_md_start,
  input  logic              e_md_div,
  output logic              pc_en,
  output logic              fd_en,
  output logic              de_clr,
  output logic              md_busy
`ifdef HAZARD_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              stall_rs, stall_rt, stall_md, stall;

  // Busy sequencer state and counter register; reset forces IDLE mid-count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: load the latency on a start in IDLE, count down in BUSY,
  // and ignore any start that arrives while already busy.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (e_md_start) begin
          cnt_nxt   = e_md_div ? DIV_LOAD : MULT_LOAD;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt <= CNT_ONE) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Dependency and busy stall decode; register 0 is never a real producer.
  always_comb begin
    stall_rs = (d_rs != '0) &&
               (((d_rs == e_wa) && (d_tuse_rs < e_tnew)) ||
                ((d_rs == m_wa) && (d_tuse_rs < m_tnew)));
    stall_rt = (d_rt != '0) &&
               (((d_rt == e_wa) && (d_tuse_rt < e_tnew)) ||
                ((d_rt == m_wa) && (d_tuse_rt < m_tnew)));
    md_busy  = e_md_start || (state == BUSY);
    stall_md = d_md_use && md_busy;
    stall    = stall_rs || stall_rt || stall_md;
    pc_en    = !stall;
    fd_en    = !stall;
    de_clr   = stall;
  end

`ifdef HAZARD_CTRL_STALL_CNT_EN
  // Count every clock edge on which the pipeline front end is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  // No stall counter in this build.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven, sequence and randomized checks of hazard_ctrl
// against a cycle-indexed behavioural model of the stall rules.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, e_wa, m_wa;
  logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic       d_md_use, e_md_start, e_md_div;
  logic       pc_en, fd_en, de_clr, md_busy;
`ifdef HAZARD_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic       md_use;
    logic [4:0] ewa;
    logic [1:0] etnew;
    logic [4:0] mwa;
    logic [1:0] mtnew;
    logic       exp_stall;
  } vec_t;

  vec_t vecs[9];

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_md_use(d_md_use), .e_wa(e_wa), .e_tnew(e_tnew), .m_wa(m_wa),
    .m_tnew(m_tnew), .e_md_start(e_md_start), .e_md_div(e_md_div),
    .pc_en(pc_en), .fd_en(fd_en), .de_clr(de_clr), .md_busy(md_busy)
`ifdef HAZARD_CTRL_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [3:0] exp);
    logic [3:0] got;
    got = {pc_en, fd_en, de_clr, md_busy};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got {pc_en,fd_en,de_clr,md_busy}=%b expected %b", name, got, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    d_rs = v.rs; d_rt = v.rt; d_tuse_rs = v.tuse_rs; d_tuse_rt = v.tuse_rt;
    d_md_use = v.md_use; e_wa = v.ewa; e_tnew = v.etnew;
    m_wa = v.mwa; m_tnew = v.mtnew;
  endtask

  task automatic clear_inputs();
    d_rs = 0; d_rt = 0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_md_use = 0;
    e_wa = 0; e_tnew = 0; m_wa = 0; m_tnew = 0; e_md_start = 0; e_md_div = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference rule for one source operand.
  function automatic bit ref_dep(int a, int tuse, int ewa, int etnew, int mwa, int mtnew);
    if (a == 0) return 0;
    return ((a == ewa) && (tuse < etnew)) || ((a == mwa) && (tuse < mtnew));
  endfunction

  initial begin
    int k;
    int busy_end;
    bit st, bz;

    vecs[0] = '{5'd8,  5'd0,  2'd1, 2'd3, 1'b0, 5'd8,  2'd2, 5'd0, 2'd0, 1'b1};
    vecs[1] = '{5'd8,  5'd0,  2'd1, 2'd3, 1'b0, 5'd0,  2'd0, 5'd8, 2'd1, 1'b0};
    vecs[2] = '{5'd0,  5'd0,  2'd0, 2'd3, 1'b0, 5'd0,  2'd2, 5'd0, 2'd0, 1'b0};
    vecs[3] = '{5'd0,  5'd9,  2'd3, 2'd0, 1'b0, 5'd0,  2'd0, 5'd9, 2'd1, 1'b1};
    vecs[4] = '{5'd0,  5'd9,  2'd3, 2'd3, 1'b0, 5'd9,  2'd2, 5'd0, 2'd0, 1'b0};
    vecs[5] = '{5'd5,  5'd0,  2'd0, 2'd3, 1'b0, 5'd5,  2'd0, 5'd0, 2'd0, 1'b0};
    vecs[6] = '{5'd5,  5'd0,  2'd0, 2'd3, 1'b0, 5'd6,  2'd2, 5'd7, 2'd2, 1'b0};
    vecs[7] = '{5'd31, 5'd31, 2'd1, 2'd0, 1'b0, 5'd31, 2'd2, 5'd0, 2'd0, 1'b1};
    vecs[8] = '{5'd0,  5'd0,  2'd3, 2'd3, 1'b1, 5'd0,  2'd0, 5'd0, 2'd0, 1'b0};

    // Reset state, including a start pulse seen during reset.
    clear_inputs();
    reset = 0;
    #12;
    check_output("reset_idle", 4'b1100);
    e_md_start = 1;
    #1;
    check_output("reset_start_comb", 4'b1101);
    e_md_start = 0;
    #1;
    reset = 1;
    next_cycle();

    // Combinational dependency table.
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i]);
      @(negedge clk);
      check_output($sformatf("dep_vec%0d", i),
                   {~vecs[i].exp_stall, ~vecs[i].exp_stall, vecs[i].exp_stall, 1'b0});
      next_cycle();
    end
    clear_inputs();

    // Fresh reset so the optional stall counter starts from zero.
    #2 reset = 0;
    #2 reset = 1;
    next_cycle();

    // Multiply with a dependent mflo in D.
    d_md_use = 1; e_md_start = 1; e_md_div = 0;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      check_output($sformatf("mult_c%0d", c), (c <= 5) ? 4'b0011 : 4'b1100);
`ifdef HAZARD_CTRL_STALL_CNT_EN
      if (c == 6) begin
        vectors++;
        if (stall_cnt !== 32'd6) begin
          miscompares++;
          $display("[TB] FAIL stall_cnt_mult: got %0d expected 6", stall_cnt);
        end
      end
`endif
      next_cycle();
      e_md_start = 0;
    end

    // Divide with an illegal second start at cycle 3 that must be ignored.
    e_md_start = 1; e_md_div = 1;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      check_output($sformatf("div_c%0d", c), (c <= 10) ? 4'b0011 : 4'b1100);
      next_cycle();
      e_md_start = (c + 1 == 3);
    end
    clear_inputs();

    // Asynchronous reset in the middle of a divide.
    e_md_start = 1; e_md_div = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_output($sformatf("rstdiv_c%0d", c), 4'b1101);
      next_cycle();
      e_md_start = 0;
    end
    #1 reset = 0;
    #1 check_output("rstdiv_async", 4'b1100);
    #1 reset = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_output($sformatf("rstdiv_post%0d", c), 4'b1100);
      next_cycle();
    end

    // Randomized run against a cycle-indexed model: busy_end is the last
    // cycle number in which the unit is occupied after a start.
    k = 0;
    busy_end = -1;
    for (int i = 0; i < 400; i++) begin
      d_rs = 5'($urandom_range(0, 3)); d_rt = 5'($urandom_range(0, 3));
      e_wa = 5'($urandom_range(0, 3)); m_wa = 5'($urandom_range(0, 3));
      d_tuse_rs = 2'($urandom_range(0, 3)); d_tuse_rt = 2'($urandom_range(0, 3));
      e_tnew = 2'($urandom_range(0, 3)); m_tnew = 2'($urandom_range(0, 3));
      d_md_use = ($urandom_range(0, 3) == 0);
      e_md_start = ($urandom_range(0, 9) == 0);
      e_md_div = 1'($urandom_range(0, 1));
      bz = e_md_start || (k <= busy_end);
      st = ref_dep(d_rs, d_tuse_rs, e_wa, e_tnew, m_wa, m_tnew) ||
           ref_dep(d_rt, d_tuse_rt, e_wa, e_tnew, m_wa, m_tnew) ||
           (d_md_use && bz);
      @(negedge clk);
      check_output($sformatf("rand%0d", i), {~st, ~st, st, bz});
      @(posedge clk);
      if (e_md_start && !(k <= busy_end))
        busy_end = k + (e_md_div ? 10 : 5);
      k++;
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives the hold enables of the PC and F/D register and the bubble-insert clear of the D/E register.
- Decides stalls from the Tuse/Tnew register-dependency comparison and from an internal multiply/divide busy sequencer.
- Sits beside the D stage and consumes decoded fields from D, E and M.

Parameters:
- ADDR_W, 5, register address width.
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.
- CNT_W, 4, width of the busy down-counter; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- d_rs  in  ADDR_W  rs read by the D-stage instruction.
- d_rt  in  ADDR_W  rt read by the D-stage instruction.
- d_tuse_rs  in  2  cycles until D needs rs; 3 = not used.
- d_tuse_rt  in  2  cycles until D needs rt; 3 = not used.
- d_md_use  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- e_wa  in  ADDR_W  E-stage destination register.
- e_tnew  in  2  cycles until the E result is ready.
- m_wa  in  ADDR_W  M-stage destination register.
- m_tnew  in  2  cycles until the M result is ready.
- e_md_start  in  1  E-stage instruction is mult/multu/div/divu (one-cycle pulse).
- e_md_div  in  1  qualifies e_md_start: 1 = divide.
- pc_en  out  1  PC update enable.
- fd_en  out  1  F/D register load enable; 0 = hold.
- de_clr  out  1  synchronous clear of the D/E register (bubble).
- md_busy  out  1  multiply/divide unit occupied.

Behaviour:
- Dependency stall, combinational:
  - stall_rs = (d_rs != 0) & ((d_rs == e_wa & d_tuse_rs < e_tnew) | (d_rs == m_wa & d_tuse_rs < m_tnew)).
  - stall_rt is defined the same way with d_rt and d_tuse_rt.
  - Address 0 never stalls.
  - e_wa/m_wa of 0 are treated as no-write.
- Busy sequencer, two states:
  - IDLE: cnt = 0. On e_md_start, load cnt = (e_md_div ? DIV_CYCLES : MULT_CYCLES) and go to BUSY.
  - BUSY: cnt decrements by 1 per cycle. Return to IDLE when cnt reaches 0 at the clock edge where cnt == 1.
  - e_md_start seen in BUSY is ignored, with no reload. This case cannot occur legally because D is stalled.
- md_busy = e_md_start | (state == BUSY).
  - Start at edge t: md_busy is high in the start cycle plus N following cycles.
- stall_md = d_md_use & md_busy.
- stall = stall_rs | stall_rt | stall_md.
  - pc_en = ~stall.
  - fd_en = ~stall.
  - de_clr = stall.
  - All three are combinational from inputs and state, with no added latency.
- Simultaneous conditions:
  - A dependency stall and a busy stall at the same time produce one stall; the outputs are not additive.
  - A stall has no effect on the sequencer; counting continues.
- Reset (reset = 0), at any time including mid-count:
  - state = IDLE, cnt = 0.
  - md_busy = 0 unless e_md_start is high.
  - pc_en/fd_en = 1 and de_clr = 0, unless combinational stall inputs are active.
- Reset release: the first count starts on the first rising edge with reset = 1.
- Counter never underflows: no decrement happens in IDLE.

Optional Feature:
- Macro: HAZARD_CTRL_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt, 32-bit.
  - Increments on every rising edge where stall = 1 and reset = 1.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared asynchronously by reset.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Load-use: E holds lw with e_wa = 8, e_tnew = 2; D holds add with d_rs = 8, d_tuse_rs = 1 -> stall = 1. Next cycle, M holds lw with m_tnew = 1, d_tuse_rs = 1 -> stall = 0.
- Zero register: d_rs = 0, e_wa = 0, e_tnew = 2, d_tuse_rs = 0 -> pc_en = 1, de_clr = 0.
- Multiply: e_md_start = 1, e_md_div = 0 at cycle 0; D holds mflo (d_md_use = 1) -> md_busy and stall high for cycles 0..5; pc_en = 1 at cycle 6.
- Divide: e_md_div = 1 -> md_busy high for cycles 0..10. A second e_md_start at cycle 3 is ignored, so md_busy falls after cycle 10.
- Mid-count reset: start a div, drive reset = 0 at cycle 4 (asynchronous, between edges) -> md_busy = 0 immediately. After release with no start, md_busy stays 0.
- With HAZARD_CTRL_STALL_CNT_EN: run the multiply scenario -> stall_cnt = 6. Preload near 0xFFFFFFFF via a long stall -> wraps to 0.
